// File: rtl/bram_req_pkg.sv
// Shared types and helpers for the BRAM request port: FSM states, word-address
// width, full-strobe constant and the read-modify-write byte merge.
package bram_req_pkg;

  localparam int unsigned MEM_AW = 14;
  localparam logic [3:0]  BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RMW_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // Lane i comes from new_word where be[i] is set, otherwise from old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_req_port.sv
// Single-outstanding request port driving one BRAM port; partial writes use
// read-modify-write. Define BRAM_REQ_RANGE_CHECK_EN to reject out-of-range or misaligned addresses.
module bram_req_port
  import bram_req_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  output logic [3:0]        mem_en,
  input  logic [31:0]       mem_dout
);

  // Handshakes: a request transfers on a cycle with req_valid && req_ready,
  // a response on a cycle with rsp_valid && rsp_ready; both sides hold until then.

  state_t            r_state;
  logic              r_alive;
  logic [MEM_AW-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_range_bad;

`ifdef BRAM_REQ_RANGE_CHECK_EN
  assign w_range_bad = (req_addr[31:16] != 16'h0000) || (req_addr[1:0] != 2'b00);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{req_addr[31:16], req_addr[1:0]};
  assign w_range_bad   = 1'b0;
`endif

  // r_alive keeps req_ready low during reset and rises on the first clock after release.
  assign req_ready = r_alive && (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // BRAM controls are live only in the acceptance cycle or the RMW write cycle.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    mem_en   = 4'h0;
    if (w_accept && !w_range_bad) begin
      if (!req_we) begin
        mem_en   = BE_FULL;
        mem_addr = req_addr[15:2];
      end else if (req_be == BE_FULL) begin
        mem_en   = BE_FULL;
        mem_we   = 1'b1;
        mem_din  = req_wdata;
        mem_addr = req_addr[15:2];
      end else if (req_be != 4'h0) begin
        mem_en   = BE_FULL;
        mem_addr = req_addr[15:2];
      end
    end else if (r_state == ST_RMW_WAIT) begin
      mem_en   = BE_FULL;
      mem_we   = 1'b1;
      mem_addr = r_addr;
      mem_din  = merge_bytes(mem_dout, r_wdata, r_be);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr[15:2];
            r_be    <= req_be;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
            if (w_range_bad) begin
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else if (!req_we) begin
              r_state <= ST_RD_WAIT;
            end else if ((req_be == BE_FULL) || (req_be == 4'h0)) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_RMW_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          r_rdata <= mem_dout;
          r_state <= ST_RESP;
        end
        ST_RMW_WAIT: begin
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_req_port.sv
// Directed bench for bram_req_port with a behavioural byte-lane BRAM model.
module tb_bram_req_port;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [3:0]  mem_en;
  logic [31:0] mem_dout;

  int n_tests;
  int n_fail;

  bram_req_port dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_en    (mem_en),
    .mem_dout  (mem_dout)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- BRAM model ----------------
  // Writes the whole word, zeroing lanes whose enable is 0; read-first output.
  logic [31:0] mem [0:16383];
  logic        pl_en;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;
  int          wr_count;

  initial begin
    wr_count = 0;
    mem_dout = '0;
  end

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_en != 4'h0) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_din & {{8{mem_en[3]}}, {8{mem_en[2]}}, {8{mem_en[1]}}, {8{mem_en[0]}}};
        wr_count <= wr_count + 1;
      end
      mem_dout <= mem[mem_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_be    = be;
    req_wdata = wd;
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_we    = 1'b1;
    req_be    = 4'hF;
    req_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check_eq({tag, "_ready_after"}, req_ready, 1);
    check_eq({tag, "_valid_after"}, rsp_valid, 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive_req(a, 1'b0, 4'h0, 32'h0);
    check_eq({tag, "_en"},   mem_en, 4'hF);
    check_eq({tag, "_we"},   mem_we, 0);
    check_eq({tag, "_addr"}, mem_addr, a[15:2]);
    tick();
    idle_req();
    #1;
    check_eq({tag, "_n1_valid"}, rsp_valid, 0);
    check_eq({tag, "_n1_en"},    mem_en, 4'h0);
    tick();
    check_eq({tag, "_valid"}, rsp_valid, 1);
    check_eq({tag, "_rdata"}, rsp_rdata, exp);
    check_eq({tag, "_err"},   rsp_err, 0);
    finish_rsp(tag);
  endtask

  // ---------------- stimulus ----------------
  int wr_before;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    rsp_ready = 1'b0;
    idle_req();
    rstn      = 1'b0;

    // Reset state, with a request presented that must not reach the BRAM.
    tick();
    drive_req(32'h10, 1'b0, 4'h0, 32'h0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_mem_en",    mem_en, 4'h0);
    check_eq("rst_mem_addr",  mem_addr, 14'h0);
    check_eq("rst_rsp_err",   rsp_err, 0);
    idle_req();
    preload(14'd4,  32'hDEAD_BEEF);
    preload(14'd8,  32'h1122_3344);
    preload(14'd12, 32'h5566_7788);
    preload(14'd1,  32'h0000_0000);
    rstn = 1'b1;
    tick();
    check_eq("post_rst_ready", req_ready, 1);
    check_eq("idle_mem_en",    mem_en, 4'h0);

    // Plain read of word 4.
    do_read("rd4", 32'h0000_0010, 32'hDEAD_BEEF);

    // Partial write into word 8; inputs scrambled after acceptance.
    drive_req(32'h0000_0020, 1'b1, 4'b0010, 32'h0000_AA00);
    check_eq("rmw_n_en",   mem_en, 4'hF);
    check_eq("rmw_n_we",   mem_we, 0);
    check_eq("rmw_n_addr", mem_addr, 14'd8);
    tick();
    idle_req();
    #1;
    check_eq("rmw_n1_we",    mem_we, 1);
    check_eq("rmw_n1_en",    mem_en, 4'hF);
    check_eq("rmw_n1_addr",  mem_addr, 14'd8);
    check_eq("rmw_n1_din",   mem_din, 32'h1122_AA44);
    check_eq("rmw_n1_valid", rsp_valid, 0);
    tick();
    check_eq("rmw_valid", rsp_valid, 1);
    check_eq("rmw_rdata", rsp_rdata, 32'h0);
    check_eq("rmw_mem8",  mem[8], 32'h1122_AA44);
    finish_rsp("rmw");
    do_read("rmw_rb", 32'h0000_0020, 32'h1122_AA44);

    // Full write with response back-pressure.
    wr_before = wr_count;
    drive_req(32'h0000_0004, 1'b1, 4'hF, 32'hCAFE_F00D);
    check_eq("fw_we",   mem_we, 1);
    check_eq("fw_en",   mem_en, 4'hF);
    check_eq("fw_din",  mem_din, 32'hCAFE_F00D);
    check_eq("fw_addr", mem_addr, 14'd1);
    tick();
    idle_req();
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("fw_hold_valid", rsp_valid, 1);
      check_eq("fw_hold_ready", req_ready, 0);
      check_eq("fw_hold_mem_en", mem_en, 4'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("fw_hs_ready", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    #1;
    check_eq("fw_after_ready", req_ready, 1);
    check_eq("fw_wr_count", wr_count - wr_before, 1);
    check_eq("fw_mem1", mem[1], 32'hCAFE_F00D);
    do_read("fw_rb", 32'h0000_0004, 32'hCAFE_F00D);

    // Write with no strobes: no BRAM access at all.
    wr_before = wr_count;
    drive_req(32'h0000_0030, 1'b1, 4'h0, 32'h1234_5678);
    check_eq("be0_en", mem_en, 4'h0);
    check_eq("be0_we", mem_we, 0);
    tick();
    idle_req();
    #1;
    check_eq("be0_valid", rsp_valid, 1);
    check_eq("be0_err",   rsp_err, 0);
    check_eq("be0_rdata", rsp_rdata, 32'h0);
    finish_rsp("be0");
    check_eq("be0_wr_count", wr_count - wr_before, 0);
    check_eq("be0_mem12",    mem[12], 32'h5566_7788);

    // Reset while a partial write is pending in RMW_WAIT.
    wr_before = wr_count;
    drive_req(32'h0000_0030, 1'b1, 4'b0001, 32'h0000_00FF);
    tick();
    idle_req();
    rstn = 1'b0;
    #1;
    check_eq("rmwrst_we",    mem_we, 0);
    check_eq("rmwrst_en",    mem_en, 4'h0);
    check_eq("rmwrst_valid", rsp_valid, 0);
    tick();
    rstn = 1'b1;
    tick();
    check_eq("rmwrst_ready",    req_ready, 1);
    check_eq("rmwrst_wr_count", wr_count - wr_before, 0);
    check_eq("rmwrst_mem12",    mem[12], 32'h5566_7788);

`ifdef BRAM_REQ_RANGE_CHECK_EN
    // Out-of-range read and misaligned write are rejected without BRAM access.
    wr_before = wr_count;
    drive_req(32'h0001_0000, 1'b0, 4'h0, 32'h0);
    check_eq("oor_en", mem_en, 4'h0);
    tick();
    idle_req();
    #1;
    check_eq("oor_valid", rsp_valid, 1);
    check_eq("oor_err",   rsp_err, 1);
    check_eq("oor_rdata", rsp_rdata, 32'h0);
    finish_rsp("oor");
    check_eq("oor_err_clr", rsp_err, 0);
    drive_req(32'h0000_0022, 1'b1, 4'hF, 32'hAAAA_5555);
    check_eq("mis_en", mem_en, 4'h0);
    tick();
    idle_req();
    #1;
    check_eq("mis_valid", rsp_valid, 1);
    check_eq("mis_err",   rsp_err, 1);
    finish_rsp("mis");
    check_eq("rng_wr_count", wr_count - wr_before, 0);
`else
    // Without range checking the upper and lowest address bits are ignored.
    do_read("wrap", 32'h0001_0013, 32'hDEAD_BEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
